// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner states, register offsets and STATUS/CTRL bit positions
// shared by the keypad controller and its key FIFO.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } kp_state_t;

    localparam int DATA_OFS   = 0;
    localparam int STATUS_OFS = 1;
    localparam int CTRL_OFS   = 2;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 11;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_IRQ_MASK = 2;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/key_fifo.sv
// key_fifo: synchronous key-code queue with flush and sticky overflow.
// A push into a full queue is dropped and flags overflow.
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     clr_ovf,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_push) - CW'(do_pop);
            end
            if (clr_ovf)          overflow <= 1'b0;
            else if (push & full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/keypad_fifo_ctrl.sv
// keypad_fifo_ctrl: scanned, debounced matrix keypad feeding a CPU-drained FIFO.
// Define KEYPAD_IRQ_EN to add the masked, registered non-empty interrupt.
module keypad_fifo_ctrl
    import keypad_pkg::*;
#(
    parameter int              ROWS            = 4,
    parameter int              COLS            = 4,
    parameter int              FIFO_DEPTH      = 8,
    parameter int              SCAN_CYCLES     = 1000,
    parameter int              DEBOUNCE_CYCLES = 50000,
    parameter int              ADDR_W          = 12,
    parameter int              DATA_W          = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 12'h900
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ROWS-1:0]   rowwrite,
    input  logic [COLS-1:0]   colread,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_out,
    input  logic              mem_wrt,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              irq
);

    localparam int RW        = $clog2(ROWS);
    localparam int CLW       = $clog2(COLS);
    localparam int CODE_W    = $clog2(ROWS * COLS);
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1;
    // Row settle time also covers the column synchroniser latency.
    localparam int SCAN_LAST = SCAN_CYCLES + SYNC_STAGES - 1;
    localparam int DEB_LAST  = DEBOUNCE_CYCLES - 1;
    localparam int TMAX      = (SCAN_LAST > DEB_LAST) ? SCAN_LAST : DEB_LAST;
    localparam int TW        = $clog2(TMAX + 1) + 1;

    kp_state_t         state, state_n;
    logic [RW-1:0]     row, row_n, row_next;
    logic [CLW-1:0]    col, col_n, low_col;
    logic [TW-1:0]     tmr, tmr_n;
    logic [COLS-1:0]   col_meta, col_sync;
    logic              any_low, key_low, push;
    logic [CODE_W-1:0] code, head;
    logic [FCW-1:0]    count;
    logic              full, empty, overflow;
    logic              sel_data, sel_status, sel_ctrl;
    logic              pop, ctrl_wr, flush, clr_ovf;
    logic              irq_mask;
    logic              unused_wdata;

    assign unused_wdata = &{1'b0, data_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= colread;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        any_low = 1'b0;
        low_col = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!col_sync[i]) begin
                any_low = 1'b1;
                low_col = CLW'(i);
            end
        end
    end

    assign key_low  = ~col_sync[col];
    assign row_next = (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
    assign rowwrite = ~(ROWS'(1) << row);
    assign code     = CODE_W'(int'(row) * COLS + int'(col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            row   <= '0;
            col   <= '0;
            tmr   <= '0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            tmr   <= tmr_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        tmr_n   = tmr + 1'b1;
        push    = 1'b0;
        unique case (state)
            SCAN: begin
                if (tmr == TW'(SCAN_LAST)) begin
                    tmr_n = '0;
                    if (any_low) begin
                        state_n = DEB_PRESS;
                        col_n   = low_col;
                    end else begin
                        row_n = row_next;
                    end
                end
            end
            DEB_PRESS: begin
                if (!key_low) begin
                    state_n = SCAN;
                    row_n   = row_next;
                    tmr_n   = '0;
                end else if (tmr == TW'(DEB_LAST)) begin
                    push    = 1'b1;
                    state_n = HELD;
                    tmr_n   = '0;
                end
            end
            HELD: begin
                tmr_n = '0;
                if (!key_low) state_n = DEB_REL;
            end
            DEB_REL: begin
                if (key_low) begin
                    state_n = HELD;
                    tmr_n   = '0;
                end else if (tmr == TW'(DEB_LAST)) begin
                    state_n = SCAN;
                    row_n   = '0;
                    tmr_n   = '0;
                end
            end
        endcase
    end

    assign sel_data   = (address == BASE_ADDR + ADDR_W'(DATA_OFS));
    assign sel_status = (address == BASE_ADDR + ADDR_W'(STATUS_OFS));
    assign sel_ctrl   = (address == BASE_ADDR + ADDR_W'(CTRL_OFS));
    assign hit        = sel_data | sel_status | sel_ctrl;
    assign pop        = rd_en & sel_data;
    assign ctrl_wr    = mem_wrt & sel_ctrl;
    assign flush      = ctrl_wr & data_out[CTRL_FLUSH];
    assign clr_ovf    = ctrl_wr & data_out[CTRL_CLR_OVF];

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .din      (code),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_data: begin
                rdata[DATA_W-1] = ~empty;
                if (!empty) rdata[CODE_W-1:0] = head;
            end
            sel_status: begin
                rdata[ST_NEMPTY]             = ~empty;
                rdata[ST_FULL]               = full;
                rdata[ST_OVF]                = overflow;
                rdata[ST_CNT_HI:ST_CNT_LO]   = 8'(count);
            end
            sel_ctrl: rdata[CTRL_IRQ_MASK] = irq_mask;
            default: ;
        endcase
    end

`ifdef KEYPAD_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_mask <= data_out[CTRL_IRQ_MASK];
            irq_q <= irq_mask & ~empty;
        end
    end

    assign irq = irq_q;
`else
    assign irq_mask = 1'b0;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_fifo_ctrl.sv
// tb_keypad_fifo_ctrl: directed keypad scenarios against hand-computed values.
// Irq expectations follow KEYPAD_IRQ_EN when it is defined for the build.
module tb_keypad_fifo_ctrl;

    localparam logic [11:0] BASE = 12'h900;
    localparam logic [11:0] STAT = 12'h901;
    localparam logic [11:0] CTRL = 12'h902;
    localparam int          GAP  = 20;
`ifdef KEYPAD_IRQ_EN
    localparam logic        IRQ_ON = 1'b1;
`else
    localparam logic        IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rowwrite;
    logic [3:0]  colread;
    logic [11:0] address;
    logic [15:0] data_out;
    logic        mem_wrt;
    logic        rd_en;
    logic [15:0] rdata;
    logic        hit;
    logic        irq;

    logic        key_dn;
    logic [1:0]  key_r;
    logic [1:0]  key_c;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    keypad_fifo_ctrl #(
        .ROWS            (4),
        .COLS            (4),
        .FIFO_DEPTH      (4),
        .SCAN_CYCLES     (2),
        .DEBOUNCE_CYCLES (4),
        .ADDR_W          (12),
        .DATA_W          (16),
        .BASE_ADDR       (12'h900)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rowwrite (rowwrite),
        .colread  (colread),
        .address  (address),
        .data_out (data_out),
        .mem_wrt  (mem_wrt),
        .rd_en    (rd_en),
        .rdata    (rdata),
        .hit      (hit),
        .irq      (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-key matrix: the column reads low only while its row is driven.
    always_comb begin
        colread = '1;
        if (key_dn && !rowwrite[key_r]) colread[key_c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int r, input int c, input logic dn);
        key_r  = 2'(r);
        key_c  = 2'(c);
        key_dn = dn;
    endtask

    task automatic status_is(input string tag, input logic [15:0] exp);
        address = STAT;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic rd_data(input string tag, input logic [15:0] exp);
        address = BASE;
        rd_en   = 1'b1;
        #1;
        chk(tag, rdata, exp);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr_ctrl(input logic [15:0] val);
        address  = CTRL;
        data_out = val;
        mem_wrt  = 1'b1;
        tick();
        mem_wrt  = 1'b0;
    endtask

    task automatic press(input int r, input int c);
        key(r, c, 1'b1);
        repeat (40) tick();
        key(r, c, 1'b0);
        repeat (GAP) tick();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_push(input string tag, output int p);
        logic [7:0] prev;
        logic       found;
        address = STAT;
        #1;
        prev  = rdata[11:4];
        found = 1'b0;
        p     = cyc;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (rdata[11:4] != prev) begin
                found = 1'b1;
                p     = cyc;
            end
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pa, pb, pd, d, n;
        rst_n    = 1'b0;
        address  = STAT;
        data_out = '0;
        mem_wrt  = 1'b0;
        rd_en    = 1'b0;
        key(0, 0, 1'b0);
        #2;
        chk("rst_rowwrite", rowwrite, 4'b1110);
        chk("rst_status", rdata, 16'h0000);
        chk("rst_irq", irq, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;

        address = BASE + 12'd3;
        #1;
        chk("miss_hit", hit, 1'b0);
        chk("miss_rdata", rdata, 16'h0000);
        address = BASE;
        #1;
        chk("base_hit", hit, 1'b1);
        chk("data_empty", rdata, 16'h0000);

        // Clean press of row2/col1.
        press(2, 1);
        status_is("t1_status", 16'h0011);
        rd_data("t1_data", 16'h8009);
        status_is("t1_drained", 16'h0000);

        // Bouncing contact on row1/col3 never settles long enough.
        for (int i = 0; i < 5; i++) begin
            key(1, 3, 1'b1);
            repeat (3) tick();
            key(1, 3, 1'b0);
            tick();
        end
        repeat (30) tick();
        status_is("t2_bounce", 16'h0000);

        // Five keys into a four-deep queue.
        press(0, 0);
        press(1, 1);
        press(2, 2);
        press(3, 3);
        press(1, 0);
        status_is("t3_status", 16'h0047);
        rd_data("t3_d0", 16'h8000);
        rd_data("t3_d5", 16'h8005);
        rd_data("t3_d10", 16'h800A);
        rd_data("t3_d15", 16'h800F);
        rd_data("t3_empty", 16'h0000);
        status_is("t3_ovf_sticky", 16'h0004);
        wr_ctrl(16'h0002);
        status_is("t3_ovf_clr", 16'h0000);

        // Same-cycle push/pop and flush/push, timed from a measured latency.
        key(0, 1, 1'b1);
        wait_push("t4_push_a", pa);
        key(0, 1, 1'b0);
        wait_until(pa + GAP);
        key(0, 2, 1'b1);
        wait_push("t4_push_b", pb);
        key(0, 2, 1'b0);
        d = pb - pa;
        wait_until(pb + GAP);
        key(0, 3, 1'b1);
        wait_until(pb + d - 1);
        address = BASE;
        rd_en   = 1'b1;
        #1;
        chk("t4_pop_head", rdata, 16'h8001);
        tick();
        rd_en = 1'b0;
        key(0, 3, 1'b0);
        status_is("t4_push_pop", 16'h0021);
        rd_data("t4_order_2", 16'h8002);
        rd_data("t4_order_3", 16'h8003);
        wait_until(pb + d + GAP);
        key(0, 0, 1'b1);
        wait_until(pb + 2 * d - 1);
        address  = CTRL;
        data_out = 16'h0001;
        mem_wrt  = 1'b1;
        tick();
        mem_wrt  = 1'b0;
        key(0, 0, 1'b0);
        status_is("t4_flush_push", 16'h0000);
        repeat (GAP) tick();
        status_is("t4_flush_late", 16'h0000);

        // Reset while row 2 is being debounced, key still held.
        n = 0;
        while (rowwrite != 4'b1110 && n < 100) begin
            tick();
            n++;
        end
        key(2, 0, 1'b1);
        n = 0;
        while (rowwrite != 4'b1011 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_row2", rowwrite, 4'b1011);
        repeat (5) tick();
        status_is("t5_pre_rst", 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_row", rowwrite, 4'b1110);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        status_is("t5_redetect", 16'h0011);
        key(2, 0, 1'b0);
        repeat (30) tick();
        status_is("t5_once", 16'h0011);
        rd_data("t5_code", 16'h8008);

        // Interrupt on key 7.
        wr_ctrl(16'h0004);
        address = CTRL;
        #1;
        chk("t6_ctrl_rd", rdata, IRQ_ON ? 16'h0004 : 16'h0000);
        key(1, 3, 1'b1);
        wait_push("t6_push", pd);
        chk("t6_irq_push", irq, 1'b0);
        tick();
        chk("t6_irq_rise", irq, IRQ_ON);
        key(1, 3, 1'b0);
        repeat (GAP) tick();
        chk("t6_irq_hold", irq, IRQ_ON);
        rd_data("t6_data", 16'h8007);
        chk("t6_irq_pop", irq, IRQ_ON);
        tick();
        chk("t6_irq_fall", irq, 1'b0);
        status_is("t6_status", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
